// File: rtl/mac_row_seq.sv
// mac_row_seq: kernel-load / execute / drain sequencer for one mac_row.
// Optional abort port enabled by defining MAC_ROW_SEQ_ABORT_EN.
module mac_row_seq #(
  parameter int col = 8,
  parameter int addr_bw = 11,
  parameter int len_bw = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [addr_bw-1:0] kernel_base,
  input  logic [addr_bw-1:0] act_base,
  input  logic [len_bw-1:0]  act_len,
  input  logic [col-1:0]     valid_in,
`ifdef MAC_ROW_SEQ_ABORT_EN
  input  logic               abort,
`endif
  output logic               sram_cen,
  output logic [addr_bw-1:0] sram_addr,
  output logic [2:0]         inst_w,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int cw = len_bw > $clog2(col + 1) ? len_bw : $clog2(col + 1);
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, DRAIN, DONE} state_t;
  state_t state, next;
  logic [cw-1:0] cnt;
  logic [len_bw:0] drained;
  logic [addr_bw-1:0] kb_q, ab_q;
  logic [len_bw-1:0] len_q;
  logic mode_q;
  logic [1:0] iw;
  logic accept;
  logic unused_valid;
  assign accept = state == IDLE && start;
  assign unused_valid = ^valid_in[col-2:0];
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? LOAD : IDLE;
      LOAD:    next = cnt == cw'(col - 1) ? (len_q == '0 ? DRAIN : EXEC) : LOAD;
      EXEC:    next = cnt == cw'(len_q - 1'b1) ? DRAIN : EXEC;
      DRAIN:   next = cnt == cw'(col) ? DONE : DRAIN;
      default: next = IDLE;
    endcase
`ifdef MAC_ROW_SEQ_ABORT_EN
    if (abort && (state == LOAD || state == EXEC)) next = DRAIN;
`endif
  end
  // cnt restarts on every phase change; DRAIN runs col+1 cycles so the last exec leaves tile col-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      iw      <= '0;
      kb_q    <= '0;
      ab_q    <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      drained <= '0;
      err     <= 1'b0;
    end else begin
      state <= next;
      cnt   <= (next != state || state == IDLE) ? '0 : cnt + 1'b1;
      iw    <= {state == EXEC, state == LOAD};
      if (accept) begin
        kb_q    <= kernel_base;
        ab_q    <= act_base;
        len_q   <= act_len;
        mode_q  <= mode;
        drained <= '0;
        err     <= 1'b0;
      end else begin
        if (busy && valid_in[col-1]) drained <= drained + 1'b1;
        if (state == DONE && drained != {1'b0, len_q}) err <= 1'b1;
      end
    end
  end
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign sram_cen  = !(state == LOAD || state == EXEC);
  assign sram_addr = state == LOAD ? kb_q + addr_bw'(cnt) :
                     state == EXEC ? ab_q + addr_bw'(cnt) : '0;
  assign inst_w    = {busy & mode_q, iw};
endmodule

// File: tb/tb_mac_row_seq.sv
// tb_mac_row_seq: cycle-indexed model of mac_row_seq jobs plus directed literal checks.
module tb_mac_row_seq;
  localparam int col = 8;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, drop = 1'b0;
  logic [10:0] kernel_base = '0, act_base = '0;
  logic [7:0] act_len = '0;
  logic [col-1:0] valid_in = '0;
  logic sram_cen, busy, done, err;
  logic [10:0] sram_addr;
  logic [2:0] inst_w;
`ifdef MAC_ROW_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif
  int checks = 0, errors = 0;
  bit active = 0, err_m = 0, m_md = 0;
  int t = 0, e_end = 0, cnt = 0, m_len = 0, m_kb = 0, m_ab = 0;
  logic [10:0] a_log [0:99];
  logic c_log [0:99];
  logic e_log [0:99];
  logic [2:0] iw_log [0:99];
  int dc;

  mac_row_seq #(.col(col), .addr_bw(11), .len_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .kernel_base(kernel_base), .act_base(act_base), .act_len(act_len),
    .valid_in(valid_in),
`ifdef MAC_ROW_SEQ_ABORT_EN
    .abort(abort),
`endif
    .sram_cen(sram_cen), .sram_addr(sram_addr), .inst_w(inst_w),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  // mac_row stand-in: each exec instruction reaches the last tile col cycles later
  always @(posedge clk) valid_in <= {valid_in[col-2:0], inst_w[1] & ~drop};

  // job model: t counts cycles since start; e_end is the last cycle that issues an address
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 0;
      t <= 0;
      err_m <= 0;
      cnt <= 0;
    end else if (active) begin
      if (t == e_end + col + 2) begin
        err_m <= (cnt != m_len);
        active <= 0;
      end
      if (valid_in[col-1]) cnt <= cnt + 1;
`ifdef MAC_ROW_SEQ_ABORT_EN
      if (abort && t <= e_end) e_end <= t;
`endif
      t <= t + 1;
    end else if (start) begin
      active <= 1;
      t <= 1;
      cnt <= 0;
      err_m <= 0;
      m_len <= int'(act_len);
      m_kb <= int'(kernel_base);
      m_ab <= int'(act_base);
      m_md <= mode;
      e_end <= col + int'(act_len);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    bit rd;
    int ea, lim;
    rd = active && t <= e_end;
    ea = rd ? ((t <= col ? m_kb + t - 1 : m_ab + t - col - 1) & 'h7FF) : 0;
    lim = (e_end < col ? e_end : col) + 1;
    chk("busy", int'(busy), int'(active));
    chk("sram_cen", int'(sram_cen), int'(!rd));
    chk("sram_addr", int'(sram_addr), ea);
    chk("inst_w0", int'(inst_w[0]), int'(active && t >= 2 && t <= lim));
    chk("inst_w1", int'(inst_w[1]), int'(active && t >= col + 2 && t <= e_end + 1));
    chk("inst_w2", int'(inst_w[2]), int'(active && m_md));
    chk("done", int'(done), int'(active && t == e_end + col + 2));
    chk("err", int'(err), int'(err_m));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      cmp_model();
    end
  endtask

  task automatic run_job(input int kb, input int ab, input int len, input bit md,
                         input int drop_at, input int ign_at, input int ab_at,
                         input int rst_at, output int dcyc);
    int c;
    @(posedge clk);
    #1;
    kernel_base = 11'(kb);
    act_base = 11'(ab);
    act_len = 8'(len);
    mode = md;
    start = 1'b1;
    drop = 1'b0;
    c = 0;
    dcyc = -1;
    forever begin
      @(negedge clk);
      cmp_model();
      a_log[c] = sram_addr;
      c_log[c] = sram_cen;
      e_log[c] = err;
      iw_log[c] = inst_w;
      if (done) begin
        dcyc = c;
        break;
      end
      if (c >= 90) begin
        checks++;
        errors++;
        $display("FAIL job_timeout: no done within %0d cycles", c);
        break;
      end
      @(posedge clk);
      #1;
      c++;
      start = (c == ign_at);
      drop = (c == drop_at);
`ifdef MAC_ROW_SEQ_ABORT_EN
      abort = (c == ab_at);
`endif
      if (c == rst_at) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_cen", int'(sram_cen), 1);
        chk("rst_addr", int'(sram_addr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_inst_w", int'(inst_w), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        break;
      end
    end
    start = 1'b0;
    drop = 1'b0;
`ifdef MAC_ROW_SEQ_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    cmp_model();
    chk("reset_cen", int'(sram_cen), 1);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b0;
    idle(2);
    // reset in the middle of EXEC (cycles 9..12 for L=4)
    run_job('h010, 'h100, 4, 1'b1, 0, 0, 0, 11, dc);
    chk("rst_no_done", dc, -1);
    idle(10);
    // L=4 job, followed back-to-back by an L=0 job
    run_job('h010, 'h100, 4, 1'b1, 0, 0, 0, 0, dc);
    chk("a_done_cycle", dc, 22);
    chk("a_addr1", int'(a_log[1]), 'h010);
    chk("a_addr8", int'(a_log[8]), 'h017);
    chk("a_addr9", int'(a_log[9]), 'h100);
    chk("a_addr12", int'(a_log[12]), 'h103);
    chk("a_cen13", int'(c_log[13]), 1);
    chk("a_iw1", int'(iw_log[1]), 'b100);
    chk("a_iw2", int'(iw_log[2]), 'b101);
    chk("a_iw9", int'(iw_log[9]), 'b101);
    chk("a_iw10", int'(iw_log[10]), 'b110);
    chk("a_iw13", int'(iw_log[13]), 'b110);
    chk("a_iw14", int'(iw_log[14]), 'b100);
    run_job('h020, 'h200, 0, 1'b0, 0, 0, 0, 0, dc);
    chk("b_done_cycle", dc, 18);
    chk("b_cen9", int'(c_log[9]), 1);
    idle(1);
    chk("b_err", int'(err), 0);
    // ignored start during EXEC, activation addresses wrapping
    run_job('h030, 'h7FE, 3, 1'b1, 0, 10, 0, 0, dc);
    chk("c_done_cycle", dc, 21);
    chk("c_addr9", int'(a_log[9]), 'h7FE);
    chk("c_addr10", int'(a_log[10]), 'h7FF);
    chk("c_addr11", int'(a_log[11]), 'h000);
    idle(3);
    // one vector lost on the way to the last tile
    run_job('h040, 'h150, 4, 1'b0, 11, 0, 0, 0, dc);
    chk("d_done_cycle", dc, 22);
    idle(4);
    chk("d_err_sticky", int'(err), 1);
    run_job('h050, 'h160, 2, 1'b1, 0, 0, 0, 0, dc);
    chk("e_err_cleared", int'(e_log[1]), 0);
    chk("e_done_cycle", dc, 20);
    idle(1);
    chk("e_err", int'(err), 0);
`ifdef MAC_ROW_SEQ_ABORT_EN
    idle(2);
    run_job('h060, 'h300, 10, 1'b1, 0, 0, 10, 0, dc);
    chk("f_cen10", int'(c_log[10]), 0);
    chk("f_cen11", int'(c_log[11]), 1);
    chk("f_iw11", int'(iw_log[11]), 'b110);
    chk("f_iw12", int'(iw_log[12]), 'b100);
    chk("f_done_cycle", dc, 20);
    idle(1);
    chk("f_err", int'(err), 1);
`endif
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
